// File: rtl/vga_sync.sv
// vga_sync: free-running raster timing generator clocked at the pixel rate.
// Drives pixel coordinates x/y, VGA sync, active-video and frame strobes.
// All decoded outputs are registered from the next counter value, so they
// describe the same pixel as the x/y presented in the same cycle.
// Optional macro VGA_SYNC_ALIGN_EN: delays hsync/vsync/video_on by two more
// clocks to line up with drawing stages that use a registered ROM address
// followed by a registered ROM output. x/y, strobes and frame_cnt are not delayed.
module vga_sync #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    output logic [10:0] x,
    output logic [9:0]  y,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic        line_start,
    output logic        frame_start,
    output logic        vblank_tick,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
    localparam logic [9:0]  V_VIS  = 10'(V_ACTIVE);
    localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Counter widths are fixed by the port list; refuse timings that overflow them.
    if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_size_chk
        $error("vga_sync: H_TOTAL/V_TOTAL do not fit x/y width");
    end

    logic [10:0] x_nxt;
    logic [9:0]  y_nxt;
    logic        hs_nxt, vs_nxt, vo_nxt, ls_nxt, fs_nxt, vt_nxt;
    logic        hs_r, vs_r, vo_r;

    // Next raster position: x wraps at end of line, y advances on that wrap.
    always_comb begin
        x_nxt = x + 11'd1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y == V_LAST) ? '0 : y + 10'd1;
        end
    end

    // Decode the upcoming pixel so the registered outputs match the new x/y.
    always_comb begin
        hs_nxt = (x_nxt >= HS_BEG && x_nxt <= HS_END) ? SYNC_POL : ~SYNC_POL;
        vs_nxt = (y_nxt >= VS_BEG && y_nxt <= VS_END) ? SYNC_POL : ~SYNC_POL;
        vo_nxt = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        ls_nxt = (x_nxt == '0);
        fs_nxt = ls_nxt && (y_nxt == '0);
        vt_nxt = ls_nxt && (y_nxt == V_VIS);
    end

    // Raster counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

    // Registered decodes and the frame counter (bumps with the vblank strobe).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_r        <= ~SYNC_POL;
            vs_r        <= ~SYNC_POL;
            vo_r        <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank_tick <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            hs_r        <= hs_nxt;
            vs_r        <= vs_nxt;
            vo_r        <= vo_nxt;
            line_start  <= ls_nxt;
            frame_start <= fs_nxt;
            vblank_tick <= vt_nxt;
            frame_cnt   <= frame_cnt + 16'(vt_nxt);
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic [1:0] hs_dly, vs_dly, vo_dly;

    // Two-stage delay of the pixel-qualifying outputs; idles at inactive levels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_dly <= {2{~SYNC_POL}};
            vs_dly <= {2{~SYNC_POL}};
            vo_dly <= 2'b00;
        end else begin
            hs_dly <= {hs_dly[0], hs_r};
            vs_dly <= {vs_dly[0], vs_r};
            vo_dly <= {vo_dly[0], vo_r};
        end
    end

    assign hsync    = hs_dly[1];
    assign vsync    = vs_dly[1];
    assign video_on = vo_dly[1];
`else
    assign hsync    = hs_r;
    assign vsync    = vs_r;
    assign video_on = vo_r;
`endif

endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: scoreboard bench for vga_sync using a shrunken raster so
// several frames fit in a short run. Honors VGA_SYNC_ALIGN_EN.
module tb_vga_sync;

    localparam int HA = 16, HFP = 2, HS = 4, HBP = 3;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HA + HFP + HS + HBP;   // 25
    localparam int VT = VA + VFP + VS + VBP;   // 17
    localparam bit POL = 1'b0;

    typedef struct packed {
        logic [10:0] x;
        logic [9:0]  y;
        logic        hs, vs, vo, ls, fs, vt;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hsync, vsync, video_on, line_start, frame_start, vblank_tick;
    logic [15:0] frame_cnt;

    vga_sync #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_POL(POL)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y),
        .hsync(hsync), .vsync(vsync), .video_on(video_on),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_tick(vblank_tick), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // reference raster state
    int          mx = 0, my = 0, cyc = 0;
    logic [15:0] mfc = '0;
    logic [1:0]  qh = {2{~POL}}, qv = {2{~POL}}, qo = 2'b00;

    // auxiliary measurements on observed outputs
    int hrun = 0, vocnt = 0, last_vt = -1, ticks = 0;
    bit full = 0, forced = 0, fc_pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (x=%0d y=%0d)", tag, obs, exp, x, y);
        end
    endtask

    function automatic exp_t rst_exp();
        exp_t e;
        e.x = '0; e.y = '0;
        e.hs = ~POL; e.vs = ~POL; e.vo = 1'b0;
        e.ls = 1'b0; e.fs = 1'b0; e.vt = 1'b0;
        e.fc = '0;
        return e;
    endfunction

    task automatic cmp(input string pfx, input exp_t e);
        chk({pfx, "x"},           32'(x),           32'(e.x));
        chk({pfx, "y"},           32'(y),           32'(e.y));
        chk({pfx, "hsync"},       32'(hsync),       32'(e.hs));
        chk({pfx, "vsync"},       32'(vsync),       32'(e.vs));
        chk({pfx, "video_on"},    32'(video_on),    32'(e.vo));
        chk({pfx, "line_start"},  32'(line_start),  32'(e.ls));
        chk({pfx, "frame_start"}, 32'(frame_start), 32'(e.fs));
        chk({pfx, "vblank_tick"}, 32'(vblank_tick), 32'(e.vt));
        chk({pfx, "frame_cnt"},   32'(frame_cnt),   32'(e.fc));
    endtask

    task automatic clear_aux();
        hrun = 0; vocnt = 0; last_vt = -1; full = 0;
        qh = {2{~POL}}; qv = {2{~POL}}; qo = 2'b00;
    endtask

    // One clock: advance the reference, queue its prediction, then compare.
    task automatic step();
        exp_t e;
        logic rh, rv, ro;
        @(posedge clk);
        cyc++;
        if (rst) begin
            mx = 0; my = 0; mfc = '0;
            clear_aux();
            e = rst_exp();
        end else begin
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
            rh = (mx >= HA + HFP && mx < HA + HFP + HS) ? POL : ~POL;
            rv = (my >= VA + VFP && my < VA + VFP + VS) ? POL : ~POL;
            ro = (mx < HA) && (my < VA);
            e.x  = 11'(mx);
            e.y  = 10'(my);
            e.ls = (mx == 0);
            e.fs = e.ls && (my == 0);
            e.vt = e.ls && (my == VA);
            if (e.vt) mfc = mfc + 16'd1;
            e.fc = mfc;
`ifdef VGA_SYNC_ALIGN_EN
            e.hs = qh[1]; e.vs = qv[1]; e.vo = qo[1];
            qh = {qh[0], rh}; qv = {qv[0], rv}; qo = {qo[0], ro};
`else
            e.hs = rh; e.vs = rv; e.vo = ro;
`endif
        end
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        cmp("", e);

        // hsync pulse width on every line
        if (hsync == POL) hrun++;
        else if (hrun != 0) begin
            chk("hs_len", 32'(hrun), 32'(HS));
            hrun = 0;
        end
        // active pixels per complete frame
        if (frame_start) begin
            if (full) chk("vo_frame", 32'(vocnt), 32'(HA * VA));
            full = 1; vocnt = 0;
        end
        if (video_on) vocnt++;
        // vblank strobe spacing
        if (vblank_tick) begin
            if (last_vt >= 0) chk("vt_gap", 32'(cyc - last_vt), 32'(HT * VT));
            last_vt = cyc;
        end
        // frame_cnt wrap after preload
        if (forced && e.vt) begin
            ticks++;
            if (ticks == 2) fc_pend = 1;
        end
        if (fc_pend && mx == 0 && my == VA + 1) begin
            chk("fc_wrap", 32'(frame_cnt), 32'h0);
            fc_pend = 0;
        end
    endtask

    initial begin
        exp_t e;
        // asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        sb.push_back(rst_exp());
        e = sb.pop_front();
        cmp("rst0_", e);
        step();
        step();
        @(negedge clk) rst = 1'b0;

        // several frames, with a frame_cnt preload in the second frame
        for (int i = 0; i < 4 * HT * VT; i++) begin
            step();
            if (!forced && i > HT * VT && mx == 3 && my == 2) begin
                #2 force dut.frame_cnt = 16'hFFFE;
                mfc = 16'hFFFE;
                forced = 1;
                step();
                #1 release dut.frame_cnt;
            end
        end
        chk("fc_ticks", 32'(ticks >= 2), 32'd1);

        // asynchronous reset mid-frame, between clock edges
        while (!(mx == 10 && my == 5)) step();
        #2 rst = 1'b1;
        #1;
        sb.push_back(rst_exp());
        e = sb.pop_front();
        cmp("rstmid_", e);
        step();
        @(negedge clk) rst = 1'b0;
        step();
        chk("restart_x", 32'(x), 32'd1);
        for (int i = 0; i < HT * VT + 100; i++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
